// File: rtl/button_conditioner.sv
// N-channel pushbutton front end: 2-flop synchroniser, debounce, and registered
// press / release / long-press (with optional auto-repeat) strobes per channel.
module button_conditioner #(
   parameter int N_BUTTONS         = 3,
   parameter int ACTIVE_LOW        = 0,
   parameter int DEBOUNCE_CYCLES   = 120000,
   parameter int LONG_PRESS_CYCLES = 12000000,
   parameter int REPEAT_CYCLES     = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [N_BUTTONS-1:0] i_buttons,
   output logic [N_BUTTONS-1:0] o_level,
   output logic [N_BUTTONS-1:0] o_press,
   output logic [N_BUTTONS-1:0] o_release,
   output logic [N_BUTTONS-1:0] o_long
);

   localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES
                                                                 : REPEAT_CYCLES;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  =
      HOLD_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_LONG
   } hold_state_t;

   logic [N_BUTTONS-1:0] pin_pressed;
   logic [N_BUTTONS-1:0] sync1;
   logic [N_BUTTONS-1:0] sync2;

   // Normalise polarity first so "released" is always 0 through the synchroniser.
   assign pin_pressed = (ACTIVE_LOW != 0) ? ~i_buttons : i_buttons;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the two sync stages into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pin_pressed;
         sync2 <= sync1;
      end
   end

   for (genvar ch = 0; ch < N_BUTTONS; ch++) begin : g_ch
      logic [DEB_W-1:0]  deb_cnt;
      logic              level_q;
      logic              press_q;
      logic              release_q;
      logic              long_q;
      logic              differs;
      logic              commit;
      logic              commit_press;
      logic              commit_release;
      hold_state_t       state;
      logic [HOLD_W-1:0] hcnt;

      assign differs        = sync2[ch] != level_q;
      assign commit         = differs && ena && (deb_cnt == DEB_LAST);
      assign commit_press   = commit && sync2[ch];
      assign commit_release = commit && !sync2[ch];

      // Debounce: a new level must disagree with o_level for DEBOUNCE_CYCLES
      // consecutive enabled cycles; any agreement restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            deb_cnt   <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= commit_press;
            release_q <= commit_release;
            if (!differs) begin
               deb_cnt <= '0;
            end else if (ena) begin
               if (commit) begin
                  level_q <= sync2[ch];
                  deb_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
         end
      end

      // Hold tracking; a release always wins over a long strobe on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= ST_IDLE;
            hcnt   <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= 1'b0;
            if (commit_release) begin
               state <= ST_IDLE;
               hcnt  <= '0;
            end else if (commit_press) begin
               state <= ST_HOLD;
               hcnt  <= '0;
            end else if (ena) begin
               case (state)
                  ST_HOLD: begin
                     if (hcnt == LONG_LAST) begin
                        long_q <= 1'b1;
                        hcnt   <= '0;
                        state  <= ST_LONG;
                     end else begin
                        hcnt <= hcnt + 1'b1;
                     end
                  end
                  ST_LONG: begin
                     // With repeat disabled the counter stays frozen until release.
                     if (REPEAT_CYCLES > 0) begin
                        if (hcnt == REP_LAST) begin
                           long_q <= 1'b1;
                           hcnt   <= '0;
                        end else begin
                           hcnt <= hcnt + 1'b1;
                        end
                     end
                  end
                  default: begin
                     hcnt <= '0;
                  end
               endcase
            end
         end
      end

      assign o_level[ch]   = level_q;
      assign o_press[ch]   = press_q;
      assign o_release[ch] = release_q;
      assign o_long[ch]    = long_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a cycle-level behavioural model
// compared on every falling edge, plus directed scenarios with literal timings.
module tb_button_conditioner;

   localparam int N    = 3;
   localparam int DEB  = 4;
   localparam int LONG = 10;
   localparam int REP  = 5;

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic [N-1:0] i_buttons;
   logic [N-1:0] o_level;
   logic [N-1:0] o_press;
   logic [N-1:0] o_release;
   logic [N-1:0] o_long;

   int n_cmp = 0;
   int n_err = 0;

   button_conditioner #(
      .N_BUTTONS        (N),
      .ACTIVE_LOW       (0),
      .DEBOUNCE_CYCLES  (DEB),
      .LONG_PRESS_CYCLES(LONG),
      .REPEAT_CYCLES    (REP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .i_buttons(i_buttons),
      .o_level  (o_level),
      .o_press  (o_press),
      .o_release(o_release),
      .o_long   (o_long)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: pin seen two edges late; level flips after DEB enabled
   // disagreeing cycles; long fires at LONG held ena-edges, then every REP.
   bit           m_s1[N];
   bit           m_s2[N];
   int           m_run[N];
   bit           m_held[N];
   int           m_hcnt[N];
   logic [N-1:0] m_level;
   logic [N-1:0] m_press;
   logic [N-1:0] m_release;
   logic [N-1:0] m_long;

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_s1[c] = 0; m_s2[c] = 0; m_run[c] = 0; m_held[c] = 0; m_hcnt[c] = 0;
      end
      m_level = '0; m_press = '0; m_release = '0; m_long = '0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            for (int c = 0; c < N; c++) begin
               m_press[c] = 0; m_release[c] = 0; m_long[c] = 0;
               if (m_s2[c] == m_level[c]) begin
                  m_run[c] = 0;
               end else if (ena) begin
                  m_run[c]++;
                  if (m_run[c] == DEB) begin
                     m_level[c] = m_s2[c];
                     m_run[c]   = 0;
                     if (m_level[c]) m_press[c] = 1; else m_release[c] = 1;
                  end
               end
               if (m_release[c]) begin
                  m_held[c] = 0;
               end else if (m_press[c]) begin
                  m_held[c] = 1;
                  m_hcnt[c] = 0;
               end else if (m_held[c] && ena) begin
                  m_hcnt[c]++;
                  m_long[c] = (m_hcnt[c] == LONG) ||
                              (REP > 0 && m_hcnt[c] > LONG && (m_hcnt[c] - LONG) % REP == 0);
               end
               m_s2[c] = m_s1[c];
               m_s1[c] = i_buttons[c];
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("model_level",   32'(o_level),   32'(m_level));
         check("model_press",   32'(o_press),   32'(m_press));
         check("model_release", 32'(o_release), 32'(m_release));
         check("model_long",    32'(o_long),    32'(m_long));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int  run[N];
      int  t;
      rst_n     = 1'b0;
      ena       = 1'b1;
      i_buttons = 3'b111;

      // Reset held with all pins pressed: outputs stay 0.
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         check("rst_level", 32'(o_level), 0);
         check("rst_press", 32'(o_press), 0);
         check("rst_long",  32'(o_long),  0);
      end
      i_buttons = '0;
      rst_n     = 1'b1;
      cyc(8);

      // Clean press and release on ch0: six-edge latency each way.
      i_buttons[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         check("c0_level", 32'(o_level[0]), 32'(k >= 6));
         check("c0_press", 32'(o_press[0]), 32'(k == 6));
      end
      i_buttons[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         check("c0_rel_level", 32'(o_level[0]),   32'(k < 6));
         check("c0_release",   32'(o_release[0]), 32'(k == 6));
         check("c0_long",      32'(o_long[0]),    0);
      end
      cyc(4);

      // Glitch on ch1: 3 cycles ignored, 4 cycles accepted.
      i_buttons[1] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         if (k == 3) i_buttons[1] = 1'b0;
         check("g3_level", 32'(o_level[1]), 0);
         check("g3_press", 32'(o_press[1]), 0);
      end
      i_buttons[1] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         if (k == 4) i_buttons[1] = 1'b0;
         check("g4_press", 32'(o_press[1]), 32'(k == 6));
         if (k == 6) check("g4_level", 32'(o_level[1]), 1);
      end
      cyc(10);

      // Long hold on ch2 with auto-repeat; release lands on a repeat edge.
      i_buttons[2] = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         cyc(1);
         check("h_level",   32'(o_level[2]),   32'(k >= 6 && k < 41));
         check("h_press",   32'(o_press[2]),   32'(k == 6));
         check("h_long",    32'(o_long[2]),    32'(k >= 16 && (k - 16) % 5 == 0 && k < 41));
         check("h_release", 32'(o_release[2]), 32'(k == 41));
         if (k == 35) i_buttons[2] = 1'b0;
      end
      cyc(4);

      // ch0 and ch2 together while ch1 bounces; ena dropped mid-release.
      t = 0;
      i_buttons[0] = 1'b1;
      i_buttons[2] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         t++;
         i_buttons[1] = ((t / 2) % 2) != 0;
         check("s_press0", 32'(o_press[0]), 32'(k == 6));
         check("s_press2", 32'(o_press[2]), 32'(k == 6));
         check("s_quiet1", 32'({o_level[1], o_press[1]}), 0);
      end
      i_buttons[0] = 1'b0;
      i_buttons[2] = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         cyc(1);
         t++;
         i_buttons[1] = ((t / 2) % 2) != 0;
         ena = !(j >= 2 && j < 5);
         check("e_level0",   32'(o_level[0]),   32'(j < 9));
         check("e_release0", 32'(o_release[0]), 32'(j == 9));
         check("e_release2", 32'(o_release[2]), 32'(j == 9));
         check("e_nolong",   32'(o_long),       0);
         check("e_quiet1",   32'(o_level[1]),   0);
      end
      i_buttons[1] = 1'b0;
      ena = 1'b1;
      cyc(10);

      // Async reset during a ch0 hold; held button re-registers as a new press.
      i_buttons[0] = 1'b1;
      cyc(9);
      check("r_pre_level", 32'(o_level[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("r_async_level", 32'(o_level), 0);
      check("r_async_strb",  32'({o_press, o_release, o_long}), 0);
      cyc(2);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         check("r_press",   32'(o_press[0]),   32'(k == 6));
         check("r_level",   32'(o_level[0]),   32'(k >= 6));
         check("r_norel",   32'(o_release[0]), 0);
      end
      i_buttons = '0;
      cyc(10);

      // Random phase: run-length pins, sparse ena gaps, rare resets.
      for (int c = 0; c < N; c++) run[c] = 1;
      for (int k = 0; k < 4000; k++) begin
         cyc(1);
         for (int c = 0; c < N; c++) begin
            run[c]--;
            if (run[c] <= 0) begin
               i_buttons[c] = ~i_buttons[c];
               run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 60))
                                                    : int'($urandom_range(1, 6));
            end
         end
         ena   = ($urandom_range(0, 9) != 0);
         rst_n = ($urandom_range(0, 599) != 0);
      end
      rst_n = 1'b1;
      cyc(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
